or_exec: RTL and testbench

OR_EXEC -- requirements
Module: or_exec

---
 rtl/or_exec.sv | 190 +++++++++++++++++++
 tb/tb_or_exec.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/or_exec.sv
// ============================================================================
//  or_exec : or-opt move executor, relocates the city at route position K
//            to position dst by shifting the cities in between.
//  Optional: OR_EXEC_CHECK_EN adds K/L range checking with an err pulse.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package replica_pkg;
  localparam int city_num = 8;
  localparam int city_log = $clog2(city_num);

  typedef enum logic [1:0] {
    THR = 2'd0,
    OR1 = 2'd1,
    TWO = 2'd2,
    NOP = 2'd3
  } com_t;

  typedef struct packed {
    com_t                com;
    logic [city_log-1:0] K;
    logic [city_log-1:0] L;
  } opt_t;
endpackage

module or_exec
  import replica_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                run_i,
  input  opt_t                opt,
  input  logic                dec_valid,
  input  logic                dec_accept,
  output logic [city_log-1:0] rd_addr,
  input  logic [city_log-1:0] rd_data,
  output logic                wr_en,
  output logic [city_log-1:0] wr_addr,
  output logic [city_log-1:0] wr_data,
  output logic                ready,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_DEC = 3'd1,
    S_LOAD     = 3'd2,
    S_SHIFT    = 3'd3,
    S_PLACE    = 3'd4,
    S_FIN      = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [city_log-1:0] r_k;
  logic [city_log-1:0] r_l;
  logic [city_log-1:0] r_tmp;
  logic [city_log-1:0] r_n;
  logic [city_log-1:0] r_idx;
  logic                r_up;
  logic                w_illegal;
  logic                w_start;
  logic [city_log-1:0] w_rd_pos;
  logic [city_log-1:0] w_wr_pos;

`ifdef OR_EXEC_CHECK_EN
  localparam logic [city_log:0] c_pos_max = (city_log+1)'(city_num - 1);
  logic r_err;

  assign w_illegal = (opt.K == '0) ||
                     ({1'b0, opt.K} > c_pos_max) ||
                     ({1'b0, opt.L} > c_pos_max) ||
                     (opt.L == opt.K) ||
                     (opt.L == opt.K - city_log'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == S_IDLE) && run_i && (opt.com == OR1) && w_illegal;
    end
  end

  assign err = r_err;
`else
  assign w_illegal = 1'b0;
  assign err       = 1'b0;
`endif

  assign w_start = (r_state == S_IDLE) && run_i && (opt.com == OR1) && !w_illegal;

  // SHIFT cycle idx reads source idx and writes the source read in cycle idx-1.
  assign w_rd_pos = r_up ? (r_k + city_log'(1) + r_idx) : (r_k - city_log'(1) - r_idx);
  assign w_wr_pos = r_up ? (r_k + r_idx - city_log'(1)) : (r_k - r_idx + city_log'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k   <= '0;
      r_l   <= '0;
      r_tmp <= '0;
      r_n   <= '0;
      r_idx <= '0;
      r_up  <= 1'b0;
    end else begin
      if (w_start) begin
        r_k  <= opt.K;
        r_l  <= opt.L;
        r_up <= (opt.K < opt.L);
        r_n  <= (opt.K < opt.L) ? (opt.L - opt.K) : (opt.K - opt.L - city_log'(1));
      end
      if (r_state == S_LOAD) begin
        r_idx <= '0;
      end
      if (r_state == S_SHIFT) begin
        if (r_idx == '0) begin
          r_tmp <= rd_data;
        end
        r_idx <= r_idx + city_log'(1);
      end
    end
  end

  // The first SHIFT cycle only captures the moved city; writes start at idx 1,
  // so a zero-length shift reduces to that single capture cycle.
  always_comb begin
    w_next  = r_state;
    ready   = 1'b0;
    done    = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (w_start) begin
          w_next = S_WAIT_DEC;
        end
      end
      S_WAIT_DEC: begin
        if (dec_valid) begin
          w_next = dec_accept ? S_LOAD : S_FIN;
        end
      end
      S_LOAD: begin
        rd_addr = r_k;
        w_next  = S_SHIFT;
      end
      S_SHIFT: begin
        if (r_idx < r_n) begin
          rd_addr = w_rd_pos;
        end
        if (r_idx != '0) begin
          wr_en   = 1'b1;
          wr_addr = w_wr_pos;
          wr_data = rd_data;
        end
        if (r_idx == r_n) begin
          w_next = S_PLACE;
        end
      end
      S_PLACE: begin
        wr_en   = 1'b1;
        wr_addr = r_up ? r_l : (r_l + city_log'(1));
        wr_data = r_tmp;
        w_next  = S_FIN;
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_or_exec.sv
// ============================================================================
//  tb_or_exec : self-checking bench for or_exec with a route memory model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_or_exec;
  import replica_pkg::*;

  logic                clk        = 1'b0;
  logic                reset      = 1'b0;
  logic                run_i      = 1'b0;
  logic                dec_valid  = 1'b0;
  logic                dec_accept = 1'b0;
  logic                preload    = 1'b0;
  opt_t                opt;
  logic [city_log-1:0] rd_addr;
  logic [city_log-1:0] rd_data;
  logic [city_log-1:0] wr_addr;
  logic [city_log-1:0] wr_data;
  logic                wr_en;
  logic                ready;
  logic                done;
  logic                err;

  logic [city_log-1:0] mem     [city_num];
  logic [city_log-1:0] exp_mem [city_num];

  typedef struct packed {
    logic [city_log-1:0] addr;
    logic [city_log-1:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  wr_cnt   = 0;

  always #5 clk = ~clk;

  or_exec dut (
    .clk        (clk),
    .reset      (reset),
    .run_i      (run_i),
    .opt        (opt),
    .dec_valid  (dec_valid),
    .dec_accept (dec_accept),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .ready      (ready),
    .done       (done),
    .err        (err)
  );

  // Route memory: one-cycle read latency, synchronous write.
  always @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (preload) begin
      for (int i = 0; i < city_num; i++) mem[i] <= city_log'(i);
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Write monitor: every write must match the next scoreboard entry.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        wr_cnt++;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_write: unexpected write addr=%0d data=%0d, expected none", wr_addr, wr_data);
        end else begin
          e = sb_q.pop_front();
          if (wr_addr !== e.addr || wr_data !== e.data) begin
            failures++;
            $display("FAIL sb_write: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                     wr_addr, wr_data, e.addr, e.data);
          end
        end
      end
    end
  end

  function automatic logic [23:0] pack_mem();
    logic [23:0] v;
    v = '0;
    for (int i = 0; i < city_num; i++) v[21-3*i +: 3] = mem[i];
    return v;
  endfunction

  // Reference move on exp_mem, pushing each expected write in order.
  task automatic model_move(input int k, input int l);
    logic [city_log-1:0] t;
    int n;
    t = exp_mem[k];
    if (k < l) begin
      n = l - k;
      for (int i = 1; i <= n; i++) begin
        sb_q.push_back('{addr: city_log'(k+i-1), data: exp_mem[k+i]});
        exp_mem[k+i-1] = exp_mem[k+i];
      end
      exp_mem[l] = t;
      sb_q.push_back('{addr: city_log'(l), data: t});
    end else begin
      n = k - l - 1;
      for (int i = 1; i <= n; i++) begin
        sb_q.push_back('{addr: city_log'(k-i+1), data: exp_mem[k-i]});
        exp_mem[k-i+1] = exp_mem[k-i];
      end
      exp_mem[l+1] = t;
      sb_q.push_back('{addr: city_log'(l+1), data: t});
    end
  endtask

  task automatic do_preload();
    @(posedge clk); #1 preload = 1'b1;
    @(posedge clk); #1 preload = 1'b0;
    for (int i = 0; i < city_num; i++) exp_mem[i] = city_log'(i);
  endtask

  task automatic send_run(input com_t c, input int k, input int l);
    @(posedge clk); #1;
    run_i   = 1'b1;
    opt.com = c;
    opt.K   = city_log'(k);
    opt.L   = city_log'(l);
    @(posedge clk); #1;
    run_i   = 1'b0;
  endtask

  task automatic send_dec(input bit acc);
    @(posedge clk); #1;
    dec_valid  = 1'b1;
    dec_accept = acc;
    @(posedge clk); #1;
    dec_valid  = 1'b0;
    dec_accept = 1'b0;
  endtask

  // Latency counted in edges, the decision-sampling edge being 1; -1 on timeout.
  task automatic wait_done(output int lat);
    bit found;
    found = 1'b0;
    lat   = 1;
    while (!found && lat <= 64) begin
      @(negedge clk);
      if (done === 1'b1) found = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    if (!found) lat = -1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (ready   !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b, expected 1", ready); end
    checks++; if (done    !== 1'b0) begin failures++; $display("FAIL reset_done: got %b, expected 0", done); end
    checks++; if (err     !== 1'b0) begin failures++; $display("FAIL reset_err: got %b, expected 0", err); end
    checks++; if (wr_en   !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b, expected 0", wr_en); end
    checks++; if (rd_addr !== '0)   begin failures++; $display("FAIL reset_rd_addr: got %0d, expected 0", rd_addr); end
    checks++; if (wr_addr !== '0)   begin failures++; $display("FAIL reset_wr_addr: got %0d, expected 0", wr_addr); end
    checks++; if (wr_data !== '0)   begin failures++; $display("FAIL reset_wr_data: got %0d, expected 0", wr_data); end
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_accept(input int k, input int l, input logic [23:0] exp_final);
    int n, lat, base;
    do_preload();
    n    = (k < l) ? (l - k) : (k - l - 1);
    base = wr_cnt;
    model_move(k, l);
    send_run(OR1, k, l);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL accept_ready_drop K=%0d L=%0d: got %b, expected 0", k, l, ready); end
    send_dec(1'b1);
    wait_done(lat);
    checks++; if (lat != n + 4) begin failures++; $display("FAIL accept_latency K=%0d L=%0d: got %0d, expected %0d", k, l, lat, n + 4); end
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL accept_ready_back K=%0d L=%0d: got %b, expected 1", k, l, ready); end
    checks++; if (wr_cnt - base != n + 1) begin failures++; $display("FAIL accept_write_count K=%0d L=%0d: got %0d, expected %0d", k, l, wr_cnt - base, n + 1); end
    checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL accept_sb_drain K=%0d L=%0d: got %0d pending, expected 0", k, l, sb_q.size()); sb_q.delete(); end
    checks++; if (pack_mem() !== exp_final) begin failures++; $display("FAIL accept_memory K=%0d L=%0d: got %o, expected %o", k, l, pack_mem(), exp_final); end
  endtask

  task automatic test_reject();
    int lat, base;
    do_preload();
    base = wr_cnt;
    send_run(OR1, 2, 5);
    send_dec(1'b0);
    wait_done(lat);
    checks++; if (lat != 1) begin failures++; $display("FAIL reject_latency: got %0d, expected 1", lat); end
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reject_ready_back: got %b, expected 1", ready); end
    checks++; if (wr_cnt != base) begin failures++; $display("FAIL reject_writes: got %0d, expected 0", wr_cnt - base); end
    checks++; if (pack_mem() !== 24'o01234567) begin failures++; $display("FAIL reject_memory: got %o, expected %o", pack_mem(), 24'o01234567); end
  endtask

  task automatic test_ignored();
    int lat, base, ndone;
    do_preload();
    base = wr_cnt;
    send_run(THR, 2, 5);
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL thr_ready: got %b, expected 1", ready); end
    send_dec(1'b1);
    ndone = 0;
    repeat (4) begin @(negedge clk); if (done === 1'b1) ndone++; end
    checks++; if (ndone != 0 || ready !== 1'b1) begin failures++; $display("FAIL idle_dec_ignored: got done_count=%0d ready=%b, expected 0 and 1", ndone, ready); end
    model_move(3, 4);
    send_run(OR1, 3, 4);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL busy_ready: got %b, expected 0", ready); end
    send_run(OR1, 1, 6);
    send_dec(1'b1);
    wait_done(lat);
    checks++; if (lat != 5) begin failures++; $display("FAIL busy_latency: got %0d, expected 5", lat); end
    @(posedge clk); #1;
    checks++; if (wr_cnt - base != 2) begin failures++; $display("FAIL busy_write_count: got %0d, expected 2", wr_cnt - base); end
    checks++; if (pack_mem() !== 24'o01243567) begin failures++; $display("FAIL busy_memory: got %o, expected %o", pack_mem(), 24'o01243567); end
    if (sb_q.size() != 0) sb_q.delete();
  endtask

  task automatic test_reset_abort();
    int base, ndone;
    do_preload();
    base = wr_cnt;
    model_move(2, 5);
    send_run(OR1, 2, 5);
    send_dec(1'b1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL abort_ready: got %b, expected 1", ready); end
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL abort_wr_en: got %b, expected 0", wr_en); end
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    ndone = 0;
    repeat (6) begin @(negedge clk); if (done === 1'b1) ndone++; end
    checks++; if (ndone != 0 || ready !== 1'b1) begin failures++; $display("FAIL abort_idle: got done_count=%0d ready=%b, expected 0 and 1", ndone, ready); end
    checks++; if (wr_cnt - base != 1) begin failures++; $display("FAIL abort_write_count: got %0d, expected 1", wr_cnt - base); end
    checks++; if (pack_mem() !== 24'o01334567) begin failures++; $display("FAIL abort_memory: got %o, expected %o", pack_mem(), 24'o01334567); end
  endtask

`ifdef OR_EXEC_CHECK_EN
  task automatic test_check_err();
    int base;
    base = wr_cnt;
    send_run(OR1, 0, 3);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_k0_pulse: got %b, expected 1", err); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL err_k0_ready: got %b, expected 1", ready); end
    @(posedge clk); #1;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_k0_width: got %b, expected 0", err); end
    send_run(OR1, 4, 3);
    checks++; if (err !== 1'b1 || ready !== 1'b1) begin failures++; $display("FAIL err_adjacent: got err=%b ready=%b, expected 1 and 1", err, ready); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (wr_cnt != base) begin failures++; $display("FAIL err_writes: got %0d, expected 0", wr_cnt - base); end
  endtask
`endif

  initial begin
    opt = '0;
    test_reset();
    test_accept(2, 5, 24'o01345267);
    test_accept(5, 1, 24'o01523467);
    test_accept(3, 4, 24'o01243567);
    test_reject();
    test_ignored();
    test_reset_abort();
`ifdef OR_EXEC_CHECK_EN
    test_check_err();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
